// File: rtl/instr_fetch_receiver.sv
// Requesting side of the syn/ack instruction link.
// Issues one request at a time and buffers returned words for the core.
module instr_fetch_receiver #(
    parameter int IWIDTH     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                              t_clk,
    input  logic                              t_rst,
    input  logic                              r_i_enable,
    input  logic                              r_i_flush,
    output logic                              r_o_syn,
    input  logic                              r_i_ack,
    input  logic [IWIDTH-1:0]                 r_i_instr,
    output logic                              r_o_valid,
    output logic [IWIDTH-1:0]                 r_o_instr,
    input  logic                              r_i_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   r_o_count,
    output logic                              r_o_timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [IWIDTH-1:0] mem [FIFO_DEPTH];

    logic [TW-1:0]     tmr;
    logic [TW-1:0]     tmr_n;
    logic              discard;
    logic              discard_n;
    logic              set_tmo;

    logic              in_req;
    logic              push;
    logic              pop;
    logic              has_space;

    assign r_o_valid = (count != '0);
    assign r_o_count = count;
    assign r_o_instr = mem[rd_ptr];

    // FIFO handshake qualifiers; flush cancels both sides of the cycle
    always_comb begin
        in_req    = (state == REQ);
        pop       = r_o_valid & r_i_ready & ~r_i_flush;
        push      = in_req & r_i_ack & ~discard & ~r_i_flush;
        has_space = (count - CW'(pop)) < CW'(FIFO_DEPTH);
    end

    // Request FSM next state, timer and discard bookkeeping
    always_comb begin
        state_n   = state;
        tmr_n     = tmr;
        discard_n = discard;
        set_tmo   = 1'b0;
        unique case (state)
            IDLE: begin
                if (r_i_enable && !r_i_flush && has_space) begin
                    state_n = REQ;
                    tmr_n   = '0;
                end
            end
            REQ: begin
                tmr_n = tmr + 1'b1;
                if (r_i_flush) begin
                    discard_n = 1'b1;
                end
                if (r_i_ack) begin
                    state_n   = REL;
                    discard_n = 1'b0;
                end else if (tmr == TW'(TIMEOUT - 1)) begin
                    state_n   = REL;
                    discard_n = 1'b0;
                    set_tmo   = 1'b1;
                end
            end
            REL: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // FSM state, registered syn and sticky timeout flag
    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            state       <= IDLE;
            tmr         <= '0;
            discard     <= 1'b0;
            r_o_syn     <= 1'b0;
            r_o_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            tmr         <= tmr_n;
            discard     <= discard_n;
            r_o_syn     <= (state_n == REQ);
            r_o_timeout <= r_o_timeout | set_tmo;
        end
    end

    // FIFO pointers and occupancy; flush empties the buffer
    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (r_i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; cleared on reset so the head reads zero
    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= r_i_instr;
        end
    end

endmodule

// File: tb/tb_instr_fetch_receiver.sv
// Bench for instr_fetch_receiver: transmitter model, scoreboard,
// a cycle vector table and directed multi-cycle sequences.
module tb_instr_fetch_receiver;

    localparam int ROMN = 36;

    logic        t_clk;
    logic        t_rst;
    logic        r_i_enable;
    logic        r_i_flush;
    logic        r_o_syn;
    wire         r_i_ack;
    wire  [31:0] r_i_instr;
    logic        r_o_valid;
    logic [31:0] r_o_instr;
    logic        r_i_ready;
    logic [2:0]  r_o_count;
    logic        r_o_timeout;

    logic        tx_auto;
    logic        tx_hold;
    logic        tx_ack;
    logic [31:0] tx_word;
    int          tx_idx;
    logic        man_ack;
    logic [31:0] man_instr;

    int n_chk;
    int n_fail;
    int exp_idx;
    int pops;
    int rises;
    int cyc;
    int last_rise;
    logic sb_on;
    logic per_on;
    logic syn_q;
    logic to_seen;

    assign r_i_ack   = tx_auto ? tx_ack  : man_ack;
    assign r_i_instr = tx_auto ? tx_word : man_instr;

    instr_fetch_receiver dut (
        .t_clk       (t_clk),
        .t_rst       (t_rst),
        .r_i_enable  (r_i_enable),
        .r_i_flush   (r_i_flush),
        .r_o_syn     (r_o_syn),
        .r_i_ack     (r_i_ack),
        .r_i_instr   (r_i_instr),
        .r_o_valid   (r_o_valid),
        .r_o_instr   (r_o_instr),
        .r_i_ready   (r_i_ready),
        .r_o_count   (r_o_count),
        .r_o_timeout (r_o_timeout)
    );

    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    function automatic logic [31:0] rom_w(input int i);
        return 32'hC0DE_0000 | 32'(i * 7 + 1);
    endfunction

    // Transmitter: sees syn one edge late, answers with a 1-cycle ack
    initial begin : tx_model
        logic syn_prev;
        logic armed;
        syn_prev = 1'b0;
        armed    = 1'b1;
        tx_ack   = 1'b0;
        tx_word  = '0;
        tx_idx   = 0;
        forever begin
            @(posedge t_clk);
            #1;
            tx_ack = 1'b0;
            if (tx_auto && !tx_hold && syn_prev && armed) begin
                tx_ack  = 1'b1;
                tx_word = rom_w(tx_idx);
                tx_idx  = (tx_idx + 1) % ROMN;
                armed   = 1'b0;
            end
            if (!syn_prev) armed = 1'b1;
            syn_prev = r_o_syn;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle: score a pop due at the coming edge, then move on
    task automatic step();
        if (sb_on && r_o_valid && r_i_ready && !r_i_flush) begin
            chk($sformatf("pop_word_%0d", exp_idx), r_o_instr,
                rom_w(exp_idx));
            exp_idx = (exp_idx + 1) % ROMN;
            pops++;
        end
        @(negedge t_clk);
        cyc++;
        if (r_o_syn && !syn_q) begin
            rises++;
            if (per_on && last_rise >= 0)
                chk("syn_period", 32'(cyc - last_rise), 32'd4);
            last_rise = cyc;
        end
        syn_q = r_o_syn;
        if (r_o_timeout) to_seen = 1'b1;
    endtask

    typedef struct {
        logic        en;
        logic        fl;
        logic        rdy;
        logic        ack;
        logic [31:0] ins;
        logic        e_syn;
        logic        e_val;
        logic [2:0]  e_cnt;
        logic [31:0] e_ins;
    } vec_t;

    function automatic vec_t mk(
        input logic en, input logic fl, input logic rdy, input logic ack,
        input logic [31:0] ins, input logic e_syn, input logic e_val,
        input logic [2:0] e_cnt, input logic [31:0] e_ins);
        vec_t v;
        v.en = en; v.fl = fl; v.rdy = rdy; v.ack = ack; v.ins = ins;
        v.e_syn = e_syn; v.e_val = e_val; v.e_cnt = e_cnt; v.e_ins = e_ins;
        return v;
    endfunction

    localparam logic [31:0] W0 = 32'h1111_0000;
    localparam logic [31:0] W1 = 32'h2222_0001;
    localparam logic [31:0] W2 = 32'h3333_0002;
    localparam logic [31:0] W3 = 32'h4444_0003;
    localparam logic [31:0] W4 = 32'h5555_0004;
    localparam logic [31:0] W5 = 32'h6666_0005;
    localparam logic [31:0] SP = 32'hDEAD_BEEF;
    localparam int NV = 27;

    vec_t tbl [NV];

    initial begin : main
        n_chk = 0; n_fail = 0; exp_idx = 0; pops = 0; rises = 0;
        cyc = 0; last_rise = -1; sb_on = 1'b1; per_on = 1'b0;
        syn_q = 1'b0; to_seen = 1'b0;
        tx_auto = 1'b1; tx_hold = 1'b0; man_ack = 1'b0; man_instr = '0;
        t_rst = 1'b0; r_i_enable = 1'b0; r_i_flush = 1'b0; r_i_ready = 1'b0;

        //      en fl rd ak ins  syn val cnt head
        tbl[0]  = mk(0, 0, 0, 1, SP, 0, 0, 0, '0);
        tbl[1]  = mk(1, 0, 0, 0, '0, 1, 0, 0, '0);
        tbl[2]  = mk(1, 0, 0, 0, '0, 1, 0, 0, '0);
        tbl[3]  = mk(1, 0, 0, 1, W0, 0, 1, 1, W0);
        tbl[4]  = mk(1, 0, 0, 1, SP, 0, 1, 1, W0);
        tbl[5]  = mk(1, 0, 0, 0, '0, 1, 1, 1, W0);
        tbl[6]  = mk(1, 0, 0, 1, W1, 0, 1, 2, W0);
        tbl[7]  = mk(1, 0, 0, 0, '0, 0, 1, 2, W0);
        tbl[8]  = mk(1, 0, 0, 0, '0, 1, 1, 2, W0);
        tbl[9]  = mk(1, 0, 0, 1, W2, 0, 1, 3, W0);
        tbl[10] = mk(1, 0, 0, 0, '0, 0, 1, 3, W0);
        tbl[11] = mk(1, 0, 0, 0, '0, 1, 1, 3, W0);
        tbl[12] = mk(1, 0, 0, 1, W3, 0, 1, 4, W0);
        tbl[13] = mk(1, 0, 0, 0, '0, 0, 1, 4, W0);
        tbl[14] = mk(1, 0, 0, 1, SP, 0, 1, 4, W0);
        tbl[15] = mk(1, 0, 1, 0, '0, 1, 1, 3, W1);
        tbl[16] = mk(1, 0, 0, 0, '0, 1, 1, 3, W1);
        tbl[17] = mk(1, 0, 1, 1, W4, 0, 1, 3, W2);
        tbl[18] = mk(0, 0, 1, 0, '0, 0, 1, 2, W3);
        tbl[19] = mk(0, 0, 1, 0, '0, 0, 1, 1, W4);
        tbl[20] = mk(0, 0, 1, 0, '0, 0, 0, 0, '0);
        tbl[21] = mk(0, 0, 0, 1, SP, 0, 0, 0, '0);
        tbl[22] = mk(1, 1, 0, 0, '0, 0, 0, 0, '0);
        tbl[23] = mk(1, 0, 0, 0, '0, 1, 0, 0, '0);
        tbl[24] = mk(0, 0, 0, 1, W5, 0, 1, 1, W5);
        tbl[25] = mk(0, 1, 0, 0, '0, 0, 0, 0, '0);
        tbl[26] = mk(0, 0, 0, 0, '0, 0, 0, 0, '0);

        // Reset values
        step(); step();
        chk("rst_syn", 32'(r_o_syn), 32'd0);
        chk("rst_valid", 32'(r_o_valid), 32'd0);
        chk("rst_count", 32'(r_o_count), 32'd0);
        chk("rst_instr", r_o_instr, 32'd0);
        chk("rst_timeout", 32'(r_o_timeout), 32'd0);
        t_rst = 1'b1;
        step();
        chk("idle_no_syn", 32'(r_o_syn), 32'd0);

        // Streaming: 40 words in ROM order, 4-cycle syn period
        r_i_enable = 1'b1; r_i_ready = 1'b1; per_on = 1'b1; pops = 0;
        for (int k = 0; k < 400 && pops < 40; k++) step();
        chk("t1_pops", 32'(pops), 32'd40);
        r_i_enable = 1'b0;
        for (int k = 0; k < 12; k++) step();
        per_on = 1'b0;
        chk("t1_drained", 32'(r_o_count), 32'd0);
        chk("t1_no_timeout", 32'(to_seen), 32'd0);

        // Back-pressure: four requests fill the buffer, then one slot frees
        r_i_enable = 1'b1; r_i_ready = 1'b0; rises = 0;
        for (int k = 0; k < 40; k++) step();
        chk("t2_requests", 32'(rises), 32'd4);
        chk("t2_count_full", 32'(r_o_count), 32'd4);
        chk("t2_syn_low", 32'(r_o_syn), 32'd0);
        chk("t2_head", r_o_instr, rom_w(exp_idx));
        r_i_ready = 1'b1;
        step();
        r_i_ready = 1'b0;
        chk("t2_count_3", 32'(r_o_count), 32'd3);
        chk("t2_new_req", 32'(r_o_syn), 32'd1);
        for (int k = 0; k < 6; k++) step();
        chk("t2_refill", 32'(r_o_count), 32'd4);
        chk("t2_one_more", 32'(rises), 32'd5);
        r_i_enable = 1'b0; r_i_ready = 1'b1;
        for (int k = 0; k < 8; k++) step();
        chk("t2_drained", 32'(r_o_count), 32'd0);

        // Timeout: no ack for 16 REQ cycles, then a clean retry
        begin
            int n;
            tx_hold = 1'b1; r_i_enable = 1'b1; r_i_ready = 1'b1;
            for (int k = 0; k < 10 && !r_o_syn; k++) step();
            chk("t3_syn_rise", 32'(r_o_syn), 32'd1);
            n = 0;
            for (int k = 0; k < 40 && r_o_syn; k++) begin
                n++;
                step();
            end
            tx_hold = 1'b0;
            chk("t3_req_cycles", 32'(n), 32'd16);
            chk("t3_timeout_set", 32'(r_o_timeout), 32'd1);
            chk("t3_no_push", 32'(r_o_count), 32'd0);
            pops = 0;
            for (int k = 0; k < 12; k++) step();
            r_i_enable = 1'b0;
            for (int k = 0; k < 8; k++) step();
            chk("t3_retry_pops", 32'(pops >= 1), 32'd1);
            chk("t3_sticky", 32'(r_o_timeout), 32'd1);
        end

        // Flush the cycle after syn rises with two words buffered
        r_i_enable = 1'b1; r_i_ready = 1'b0; rises = 0;
        for (int k = 0; k < 40 && rises < 3; k++) step();
        chk("t4_third_req", 32'(rises), 32'd3);
        chk("t4_count_2", 32'(r_o_count), 32'd2);
        r_i_flush = 1'b1;
        step();
        r_i_flush = 1'b0;
        exp_idx = (exp_idx + 3) % ROMN;
        chk("t4_flushed", 32'(r_o_count), 32'd0);
        chk("t4_still_req", 32'(r_o_syn), 32'd1);
        step();
        chk("t4_ack_dropped", 32'(r_o_count), 32'd0);
        chk("t4_rel", 32'(r_o_syn), 32'd0);
        r_i_ready = 1'b1; pops = 0;
        for (int k = 0; k < 12; k++) step();
        r_i_enable = 1'b0;
        for (int k = 0; k < 8; k++) step();
        chk("t4_next_pops", 32'(pops >= 1), 32'd1);

        // Cycle vectors: spurious acks, full stall, push+pop, wrap, flush
        tx_auto = 1'b0; sb_on = 1'b0;
        for (int i = 0; i < NV; i++) begin
            r_i_enable = tbl[i].en;
            r_i_flush  = tbl[i].fl;
            r_i_ready  = tbl[i].rdy;
            man_ack    = tbl[i].ack;
            man_instr  = tbl[i].ins;
            step();
            chk($sformatf("v%0d_syn", i), 32'(r_o_syn), 32'(tbl[i].e_syn));
            chk($sformatf("v%0d_valid", i), 32'(r_o_valid),
                32'(tbl[i].e_val));
            chk($sformatf("v%0d_count", i), 32'(r_o_count),
                32'(tbl[i].e_cnt));
            if (tbl[i].e_val)
                chk($sformatf("v%0d_head", i), r_o_instr, tbl[i].e_ins);
        end
        man_ack = 1'b0; r_i_flush = 1'b0;
        tx_auto = 1'b1; sb_on = 1'b1;
        for (int k = 0; k < 3; k++) step();

        // Reset in the middle of a request
        r_i_enable = 1'b1; r_i_ready = 1'b1;
        for (int k = 0; k < 10 && !r_o_syn; k++) step();
        chk("t6_in_req", 32'(r_o_syn), 32'd1);
        #2;
        t_rst = 1'b0;
        #1;
        chk("t6_rst_syn", 32'(r_o_syn), 32'd0);
        chk("t6_rst_valid", 32'(r_o_valid), 32'd0);
        chk("t6_rst_count", 32'(r_o_count), 32'd0);
        chk("t6_rst_instr", r_o_instr, 32'd0);
        chk("t6_rst_timeout", 32'(r_o_timeout), 32'd0);
        exp_idx = (exp_idx + 1) % ROMN;
        for (int k = 0; k < 3; k++) step();
        t_rst = 1'b1;
        #1;
        chk("t6_rel_idle", 32'(r_o_syn), 32'd0);
        step();
        chk("t6_restart", 32'(r_o_syn), 32'd1);
        pops = 0;
        for (int k = 0; k < 20; k++) step();
        r_i_enable = 1'b0;
        for (int k = 0; k < 8; k++) step();
        chk("t6_pops", 32'(pops >= 3), 32'd1);
        chk("t6_timeout_clear", 32'(r_o_timeout), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
